// File: rtl/rng_pkg.sv
// Shared types and widths for the RNG consumer-side read buffer.
package rng_pkg;
   localparam int RNG_DATA_W = 64;
   localparam int RNG_DROP_W = 16;

   typedef enum logic [1:0] {
      WARMUP = 2'd0,
      RUN    = 2'd1,
      FAIL   = 2'd2
   } rng_rd_state_e;
endpackage

// File: rtl/rng_rd_fifo.sv
// Small FIFO with separate occupancy counter; head is registered storage, reads 0 when empty.
// Caller guarantees no push when full without a same-cycle pop; flush has priority over push/pop.
module rng_rd_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 64
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   input  logic [W-1:0]             wdata_i,
   output logic [W-1:0]             rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   fill_o
);
   localparam int PTR_W  = $clog2(DEPTH);
   localparam int FILL_W = PTR_W + 1;

   logic [W-1:0]      mem_q [DEPTH];
   logic [W-1:0]      mem_d [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [FILL_W-1:0] fill_q, fill_d;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      fill_d   = fill_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         fill_d   = '0;
      end else begin
         if (push_i) begin
            mem_d[wr_ptr_q] = wdata_i;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (pop_i) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         case ({push_i, pop_i})
            2'b10:   fill_d = fill_q + FILL_W'(1);
            2'b01:   fill_d = fill_q - FILL_W'(1);
            default: fill_d = fill_q;
         endcase
      end
   end

   // Storage is intentionally unreset; only pointers and occupancy carry state.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fill_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         fill_q   <= fill_d;
      end
   end

   assign empty_o = (fill_q == '0);
   assign full_o  = (fill_q == FILL_W'(DEPTH));
   assign fill_o  = fill_q;
   assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
endmodule

// File: rtl/rng_rd_buf.sv
// RNG sample buffer: discards WARMUP beats, queues samples, drains over valid/ready; data visible one edge after acceptance.
// No backpressure to the generator (overflow counted as drops); define RNG_HEALTH_EN for the repetition-count health test.
module rng_rd_buf
   import rng_pkg::*;
#(
   parameter int DEPTH     = 4,
   parameter int WARMUP    = 8,
   parameter int REP_LIMIT = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [RNG_DATA_W-1:0]    rand_num_i,
   input  logic                     rand_num_valid_i,
   input  logic                     flush_i,
   output logic [RNG_DATA_W-1:0]    rnd_data_o,
   output logic                     rnd_valid_o,
   input  logic                     rnd_ready_i,
   output logic [$clog2(DEPTH):0]   fill_o,
   output logic [RNG_DROP_W-1:0]    drop_cnt_o,
   output logic                     health_err_o
);
   localparam int WARM_W = $clog2(WARMUP + 1);

   rng_rd_state_e          state_q, state_d;
   logic [WARM_W-1:0]      warm_cnt_q, warm_cnt_d;
   logic [RNG_DROP_W-1:0]  drop_cnt_q, drop_cnt_d;
   logic                   push, pop, full, empty, trip;

   assign rnd_valid_o = (state_q == rng_pkg::RUN) && !empty;
   assign pop         = rnd_valid_o && rnd_ready_i && !flush_i;

`ifdef RNG_HEALTH_EN
   localparam int REP_W = $clog2(REP_LIMIT + 1);

   logic [RNG_DATA_W-1:0]  last_q, last_d;
   logic [REP_W-1:0]       rep_cnt_q, rep_cnt_d;
   logic                   health_err_q, health_err_d;

   // Repetition run tracks every sample seen outside FAIL, but only trips in RUN.
   always_comb begin
      last_d       = last_q;
      rep_cnt_d    = rep_cnt_q;
      health_err_d = health_err_q;
      trip         = 1'b0;
      if (flush_i) begin
         last_d       = '0;
         rep_cnt_d    = '0;
         health_err_d = 1'b0;
      end else if (rand_num_valid_i && state_q != rng_pkg::FAIL) begin
         last_d = rand_num_i;
         if (rep_cnt_q != '0 && rand_num_i == last_q) begin
            rep_cnt_d = (rep_cnt_q == REP_W'(REP_LIMIT)) ? rep_cnt_q : rep_cnt_q + REP_W'(1);
         end else begin
            rep_cnt_d = REP_W'(1);
         end
         if (state_q == rng_pkg::RUN && rep_cnt_d == REP_W'(REP_LIMIT)) begin
            trip         = 1'b1;
            health_err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q       <= '0;
         rep_cnt_q    <= '0;
         health_err_q <= 1'b0;
      end else begin
         last_q       <= last_d;
         rep_cnt_q    <= rep_cnt_d;
         health_err_q <= health_err_d;
      end
   end

   assign health_err_o = health_err_q;
`else
   assign trip         = 1'b0;
   assign health_err_o = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      warm_cnt_d = warm_cnt_q;
      drop_cnt_d = drop_cnt_q;
      push       = 1'b0;
      if (flush_i) begin
         state_d    = rng_pkg::WARMUP;
         warm_cnt_d = '0;
         drop_cnt_d = '0;
      end else if (rand_num_valid_i) begin
         case (state_q)
            rng_pkg::WARMUP: begin
               warm_cnt_d = warm_cnt_q + WARM_W'(1);
               if (warm_cnt_q == WARM_W'(WARMUP - 1)) begin
                  state_d = rng_pkg::RUN;
               end
            end
            rng_pkg::RUN: begin
               if (trip) begin
                  state_d = rng_pkg::FAIL;
               end else if (!full || pop) begin
                  push = 1'b1;
               end else if (drop_cnt_q != '1) begin
                  drop_cnt_d = drop_cnt_q + RNG_DROP_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= rng_pkg::WARMUP;
         warm_cnt_q <= '0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         warm_cnt_q <= warm_cnt_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign drop_cnt_o = drop_cnt_q;

   rng_rd_fifo #(
      .DEPTH (DEPTH),
      .W     (RNG_DATA_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (flush_i),
      .wdata_i (rand_num_i),
      .rdata_o (rnd_data_o),
      .full_o  (full),
      .empty_o (empty),
      .fill_o  (fill_o)
   );
endmodule

// File: tb/tb_rng_rd_buf.sv
// Scoreboard bench for rng_rd_buf: queue-based reference model, decoupled negedge monitor.
module tb_rng_rd_buf;
   localparam int DEPTH     = 4;
   localparam int WARMUP    = 8;
   localparam int REP_LIMIT = 3;
`ifdef RNG_HEALTH_EN
   localparam bit HEALTH = 1'b1;
`else
   localparam bit HEALTH = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] rand_num_i;
   logic        rand_num_valid_i;
   logic        flush_i;
   logic [63:0] rnd_data_o;
   logic        rnd_valid_o;
   logic        rnd_ready_i;
   logic [2:0]  fill_o;
   logic [15:0] drop_cnt_o;
   logic        health_err_o;

   always #5 clk = ~clk;

   rng_rd_buf #(
      .DEPTH     (DEPTH),
      .WARMUP    (WARMUP),
      .REP_LIMIT (REP_LIMIT)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .rand_num_i       (rand_num_i),
      .rand_num_valid_i (rand_num_valid_i),
      .flush_i          (flush_i),
      .rnd_data_o       (rnd_data_o),
      .rnd_valid_o      (rnd_valid_o),
      .rnd_ready_i      (rnd_ready_i),
      .fill_o           (fill_o),
      .drop_cnt_o       (drop_cnt_o),
      .health_err_o     (health_err_o)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: mode, warm-up progress, queue contents, drop tally, repetition run.
   typedef enum int {M_WARM, M_RUN, M_FAIL} mode_e;
   mode_e       mst       = M_WARM;
   int          warm_seen = 0;
   int          drops     = 0;
   bit          herr      = 1'b0;
   int          rep       = 0;
   logic [63:0] last      = '0;
   logic [63:0] model_q[$];
   logic [63:0] sb_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit model_valid();
      return (mst == M_RUN) && (model_q.size() > 0);
   endfunction

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   task automatic model_reset();
      mst = M_WARM; warm_seen = 0; drops = 0; herr = 1'b0; rep = 0; last = '0;
      model_q.delete();
   endtask

   task automatic model_step(input bit v, input logic [63:0] d, input bit rdy, input bit fl);
      bit pop, push;
      if (fl) begin
         model_reset();
         return;
      end
      pop  = model_valid() && rdy;
      push = 1'b0;
      if (v && mst != M_FAIL) begin
         if (HEALTH) begin
            rep  = (rep > 0 && d == last) ? rep + 1 : 1;
            last = d;
         end
         if (mst == M_WARM) begin
            warm_seen++;
            if (warm_seen == WARMUP) mst = M_RUN;
         end else if (HEALTH && rep >= REP_LIMIT) begin
            mst  = M_FAIL;
            herr = 1'b1;
         end else if (model_q.size() < DEPTH || pop) begin
            push = 1'b1;
         end else if (drops < 65535) begin
            drops++;
         end
      end
      if (pop) void'(model_q.pop_front());
      if (push) begin
         model_q.push_back(d);
         sb_q.push_back(d);
      end
   endtask

   // One clock of stimulus; model advances just after the edge it describes.
   task automatic cycle(input bit v, input logic [63:0] d, input bit rdy, input bit fl);
      rand_num_valid_i = v;
      rand_num_i       = d;
      rnd_ready_i      = rdy;
      flush_i          = fl;
      @(posedge clk);
      #1;
      model_step(v, d, rdy, fl);
   endtask

   task automatic warm();
      repeat (WARMUP) cycle(1'b1, rnd64(), 1'b0, 1'b0);
   endtask

   initial begin
      forever begin
         @(negedge clk);
         chk("valid", {63'd0, rnd_valid_o}, {63'd0, model_valid()});
         chk("fill", {61'd0, fill_o}, 64'(model_q.size()));
         chk("drop_cnt", {48'd0, drop_cnt_o}, 64'(drops));
         chk("health_err", {63'd0, health_err_o}, {63'd0, herr});
         if (rnd_valid_o) begin
            if (sb_q.size() == 0) begin
               chk("data_unexpected", rnd_data_o, 64'hX);
            end else begin
               chk("data", rnd_data_o, sb_q[0]);
               if (rnd_ready_i && !flush_i && rst_n) void'(sb_q.pop_front());
            end
         end else if (model_q.size() == 0) begin
            chk("data_empty", rnd_data_o, 64'd0);
         end
         if (flush_i) sb_q.delete();
      end
   end

   initial begin
      rst_n = 1'b0; rand_num_i = '0; rand_num_valid_i = 1'b0; flush_i = 1'b0; rnd_ready_i = 1'b0;
      #1;
      chk("rst_valid", {63'd0, rnd_valid_o}, 64'd0);
      chk("rst_data", rnd_data_o, 64'd0);
      chk("rst_fill", {61'd0, fill_o}, 64'd0);
      #11 rst_n = 1'b1;

      // Warm-up: beats 1..8 discarded, beat 9 is the first output.
      for (int i = 1; i <= 8; i++) begin
         cycle(1'b1, 64'(i), 1'b0, 1'b0);
         chk("warm_valid", {63'd0, rnd_valid_o}, 64'd0);
      end
      cycle(1'b1, 64'd9, 1'b0, 1'b0);
      chk("first_data", rnd_data_o, 64'd9);
      chk("first_fill", {61'd0, fill_o}, 64'd1);
      cycle(1'b0, 64'd0, 1'b1, 1'b0);

      // Overflow at DEPTH=4, then push+pop at full.
      for (int i = 1; i <= 6; i++) cycle(1'b1, 64'(i), 1'b0, 1'b0);
      chk("ovf_fill", {61'd0, fill_o}, 64'd4);
      chk("ovf_drop", {48'd0, drop_cnt_o}, 64'd2);
      chk("ovf_head", rnd_data_o, 64'd1);
      cycle(1'b1, 64'd7, 1'b1, 1'b0);
      chk("pp_fill", {61'd0, fill_o}, 64'd4);
      chk("pp_drop", {48'd0, drop_cnt_o}, 64'd2);
      chk("pp_head", rnd_data_o, 64'd2);
      repeat (3) cycle(1'b0, 64'd0, 1'b1, 1'b0);
      chk("pp_tail", rnd_data_o, 64'd7);
      cycle(1'b0, 64'd0, 1'b1, 1'b0);
      chk("drained", {61'd0, fill_o}, 64'd0);

      // Randomized traffic with occasional flushes; small value range provokes repeats.
      for (int i = 0; i < 400; i++) begin
         cycle($urandom_range(0, 3) != 0, 64'($urandom_range(0, 3)),
               $urandom_range(0, 1) == 1, $urandom_range(0, 29) == 0);
      end

`ifdef RNG_HEALTH_EN
      cycle(1'b0, 64'd0, 1'b0, 1'b1);
      warm();
      repeat (3) cycle(1'b1, 64'hDEAD, 1'b0, 1'b0);
      chk("hlth_err", {63'd0, health_err_o}, 64'd1);
      chk("hlth_valid", {63'd0, rnd_valid_o}, 64'd0);
      repeat (2) cycle(1'b1, rnd64(), 1'b1, 1'b0);
      chk("hlth_fill", {61'd0, fill_o}, 64'd2);
      chk("hlth_drop", {48'd0, drop_cnt_o}, 64'd0);
      cycle(1'b0, 64'd0, 1'b0, 1'b1);
      chk("hlth_clr", {63'd0, health_err_o}, 64'd0);
      chk("hlth_fill0", {61'd0, fill_o}, 64'd0);
      warm();
      cycle(1'b1, 64'd5, 1'b0, 1'b0);
      chk("hlth_resume", rnd_data_o, 64'd5);
`endif

      // Drop counter saturation.
      cycle(1'b0, 64'd0, 1'b0, 1'b1);
      warm();
      for (int i = 0; i < 4; i++) cycle(1'b1, 64'(1000 + i), 1'b0, 1'b0);
      for (int i = 0; i < 65540; i++) begin
         cycle(1'b1, 64'(100000 + i), 1'b0, 1'b0);
         if (i == 65534) chk("sat_reach", {48'd0, drop_cnt_o}, 64'hFFFF);
      end
      chk("sat_hold", {48'd0, drop_cnt_o}, 64'hFFFF);

      // Asynchronous reset with three entries queued.
      cycle(1'b0, 64'd0, 1'b0, 1'b1);
      warm();
      for (int i = 0; i < 3; i++) cycle(1'b1, 64'(50 + i), 1'b0, 1'b0);
      chk("pre_rst_fill", {61'd0, fill_o}, 64'd3);
      rand_num_valid_i = 1'b0; rnd_ready_i = 1'b0; flush_i = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", {63'd0, rnd_valid_o}, 64'd0);
      chk("arst_data", rnd_data_o, 64'd0);
      chk("arst_fill", {61'd0, fill_o}, 64'd0);
      chk("arst_drop", {48'd0, drop_cnt_o}, 64'd0);
      chk("arst_hlth", {63'd0, health_err_o}, 64'd0);
      model_reset();
      sb_q.delete();
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;
      for (int i = 1; i <= 8; i++) cycle(1'b1, 64'(i), 1'b1, 1'b0);
      chk("rst_warm_valid", {63'd0, rnd_valid_o}, 64'd0);
      cycle(1'b1, 64'd9, 1'b0, 1'b0);
      chk("rst_first_data", rnd_data_o, 64'd9);
      repeat (2) cycle(1'b0, 64'd0, 1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
